// File: rtl/mpy_seq_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// State encodings are fixed so that debug dumps stay comparable across builds.
package mpy_seq_pkg;

  localparam int MPY_DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    MPY_IDLE = 2'd0,
    MPY_CALC = 2'd1,
    MPY_FIN  = 2'd2
  } mpy_state_e;

endpackage

// File: rtl/mpy_seq_if.sv
// Start/done handshake and operand/result bus between the execute stage and mpy_seq.
interface mpy_seq_if
  import mpy_seq_pkg::*;
#(
  parameter int WIDTH = MPY_DEFAULT_WIDTH
);

  logic                 start;
  logic                 sgn;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   p;
  logic                 N;
  logic                 Z;

  modport master (output start, sgn, a, b, input busy, done, p, N, Z);
  modport slave  (input start, sgn, a, b, output busy, done, p, N, Z);

endinterface

// File: rtl/mpy_seq_cneg.sv
// Combinational conditional two's-complement negate: y = c ? -x : x (modulo 2^W).
module mpy_cneg #(
  parameter int W = 8
) (
  input  logic         c,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = c ? (~x + W'(1)) : x;

endmodule

// File: rtl/mpy_seq.sv
// Radix-2 shift-add WIDTH x WIDTH multiplier behind a start/done handshake, with N/Z flags.
// Optional MPY_EARLY_TERM_EN: leave CALC as soon as the remaining multiplier bits are zero.
module mpy_seq
  import mpy_seq_pkg::*;
#(
  parameter int WIDTH = MPY_DEFAULT_WIDTH
) (
  input  logic     clk,
  input  logic     reset_n,
  mpy_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH;

  mpy_state_e       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mul_q, mul_d;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    acc_q, acc_d, p_q, p_d;
  logic [PW-1:0]    p_res, step_acc;
  logic [WIDTH:0]   hi_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d, n_q, n_d, z_q, z_d, done_q, done_d;
  logic             early_exit, last_iter;

  mpy_cneg #(.W(WIDTH)) u_mag_a (.c(bus.sgn & bus.a[WIDTH-1]), .x(bus.a), .y(a_mag));
  mpy_cneg #(.W(WIDTH)) u_mag_b (.c(bus.sgn & bus.b[WIDTH-1]), .x(bus.b), .y(b_mag));
  mpy_cneg #(.W(PW))    u_res   (.c(neg_q), .x(acc_q), .y(p_res));

  // The add carry lands in the accumulator MSB as the whole word shifts right.
  assign hi_sum    = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, mcand_q};
  assign step_acc  = mul_q[0] ? {hi_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[PW-1:1]};
  assign last_iter = (cnt_q == CNT_W'(1));

`ifdef MPY_EARLY_TERM_EN
  assign early_exit = (mul_q == '0);
`else
  assign early_exit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= MPY_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MPY_IDLE: if (bus.start) state_d = MPY_CALC;
      MPY_CALC: if (early_exit || last_iter) state_d = MPY_FIN;
      MPY_FIN:  state_d = MPY_IDLE;
      default:  state_d = MPY_IDLE;
    endcase
  end

  always_comb begin
    mcand_d = mcand_q;
    mul_d   = mul_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    p_d     = p_q;
    n_d     = n_q;
    z_d     = z_q;
    done_d  = 1'b0;
    case (state_q)
      MPY_IDLE: begin
        if (bus.start) begin
          mcand_d = a_mag;
          mul_d   = b_mag;
          neg_d   = bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
        end
      end
      MPY_CALC: begin
        // Skipped iterations add nothing, so their combined effect is a plain shift.
        if (early_exit) begin
          acc_d = acc_q >> cnt_q;
        end else begin
          acc_d = step_acc;
          mul_d = mul_q >> 1;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MPY_FIN: begin
        p_d    = p_res;
        n_d    = p_res[PW-1];
        z_d    = (p_res == '0);
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q <= '0;
      mul_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      p_q     <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      mul_q   <= mul_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      p_q     <= p_d;
      n_q     <= n_d;
      z_q     <= z_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != MPY_IDLE);
  assign bus.done = done_q;
  assign bus.p    = p_q;
  assign bus.N    = n_q;
  assign bus.Z    = z_q;

endmodule

// File: tb/tb_mpy_seq.sv
// Scoreboard bench for mpy_seq at WIDTH=32 (directed + random) and WIDTH=8 (random).
// Expected results come from plain modular arithmetic on the operands' integer values.
module tb_mpy_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mpy_seq_if #(.WIDTH(32)) if32 ();
  mpy_seq_if #(.WIDTH(8))  if8 ();

  mpy_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(if32));
  mpy_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(if8));

  typedef struct {
    logic [127:0] p;
    bit           n;
    bit           z;
    int           done_cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int errors = 0, checks = 0, cyc = 0;
  int next_free32 = 0, next_free8 = 0;
  int acc32 = 0, acc8 = 0, done32 = 0, done8 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Product of the operands read as integers (two's complement when s=1), modulo 2^(2w).
  function automatic logic [127:0] ref_prod(logic [63:0] a, logic [63:0] b, bit s, int w);
    logic [127:0] lim, va, vb, pr;
    lim = 128'd1 << w;
    va  = {64'd0, a} & (lim - 128'd1);
    vb  = {64'd0, b} & (lim - 128'd1);
    if (s && a[w-1]) va = va - lim;
    if (s && b[w-1]) vb = vb - lim;
    pr = va * vb;
    return pr & ((128'd1 << (2 * w)) - 128'd1);
  endfunction

  // Clocks from the accept edge to the edge after which done is visible.
  function automatic int ref_lat(logic [63:0] b, bit s, int w);
    logic [127:0] lim, vb;
    int len;
    lim = 128'd1 << w;
    vb  = {64'd0, b} & (lim - 128'd1);
    if (s && b[w-1]) vb = lim - vb;
    len = 0;
    for (int i = 0; i < w; i++) if (vb[i]) len = i + 1;
`ifdef MPY_EARLY_TERM_EN
    return (len == w) ? w + 1 : len + 2;
`else
    return (len >= 0) ? w + 1 : 0;
`endif
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      q32.delete();
      next_free32 = 0;
      chk("rst32_busy", if32.busy, 0);
      chk("rst32_done", if32.done, 0);
      chk("rst32_p", if32.p, 0);
      chk("rst32_Z", if32.Z, 1);
      chk("rst32_N", if32.N, 0);
    end else begin
      if (if32.done) begin
        done32++;
        if (q32.size() == 0) chk("done32_unexpected", 1, 0);
        else begin
          e = q32.pop_front();
          chk("p32", if32.p, e.p);
          chk("N32", if32.N, e.n);
          chk("Z32", if32.Z, e.z);
          chk("lat32", cyc, e.done_cyc);
        end
      end
      if (q32.size() > 0 && cyc > q32[0].done_cyc) begin
        chk("done32_timeout", cyc, q32[0].done_cyc);
        void'(q32.pop_front());
      end
      chk("busy32", if32.busy, (cyc + 1 < next_free32));
      if (if32.start && cyc + 1 >= next_free32) begin
        int lat;
        lat = ref_lat({32'd0, if32.b}, if32.sgn, 32);
        e.p = ref_prod({32'd0, if32.a}, {32'd0, if32.b}, if32.sgn, 32);
        e.n = e.p[63];
        e.z = (e.p == 0);
        e.done_cyc = cyc + 1 + lat;
        q32.push_back(e);
        next_free32 = cyc + 2 + lat;
        acc32++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      q8.delete();
      next_free8 = 0;
      chk("rst8_busy", if8.busy, 0);
      chk("rst8_done", if8.done, 0);
      chk("rst8_p", if8.p, 0);
      chk("rst8_Z", if8.Z, 1);
    end else begin
      if (if8.done) begin
        done8++;
        if (q8.size() == 0) chk("done8_unexpected", 1, 0);
        else begin
          e = q8.pop_front();
          chk("p8", if8.p, e.p);
          chk("N8", if8.N, e.n);
          chk("Z8", if8.Z, e.z);
          chk("lat8", cyc, e.done_cyc);
        end
      end
      if (q8.size() > 0 && cyc > q8[0].done_cyc) begin
        chk("done8_timeout", cyc, q8[0].done_cyc);
        void'(q8.pop_front());
      end
      chk("busy8", if8.busy, (cyc + 1 < next_free8));
      if (if8.start && cyc + 1 >= next_free8) begin
        int lat;
        lat = ref_lat({56'd0, if8.b}, if8.sgn, 8);
        e.p = ref_prod({56'd0, if8.a}, {56'd0, if8.b}, if8.sgn, 8);
        e.n = e.p[15];
        e.z = (e.p == 0);
        e.done_cyc = cyc + 1 + lat;
        q8.push_back(e);
        next_free8 = cyc + 2 + lat;
        acc8++;
      end
    end
  end

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input bit s,
                       input logic [63:0] exp_p, input string nm);
    bit got;
    @(posedge clk); #2;
    if32.start = 1'b1; if32.a = a; if32.b = b; if32.sgn = s;
    @(posedge clk); #2;
    if32.start = 1'b0; if32.a = 32'($urandom); if32.b = 32'($urandom);
    if32.sgn = 1'($urandom_range(0, 1));
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (if32.done) got = 1'b1;
    end
    chk({nm, "_done_seen"}, got, 1);
    chk({nm, "_p"}, if32.p, exp_p);
    chk({nm, "_N"}, if32.N, exp_p[63]);
    chk({nm, "_Z"}, if32.Z, (exp_p == 64'd0));
  endtask

  initial begin
    int d0, a0, n;
    if32.start = 1'b0; if32.sgn = 1'b0; if32.a = '0; if32.b = '0;
    if8.start  = 1'b0; if8.sgn  = 1'b0; if8.a  = '0; if8.b  = '0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    run32(32'hFFFF_FFFD, 32'd7,        1'b1, 64'hFFFF_FFFF_FFFF_FFEB, "neg3x7");
    run32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "minneg_sq_s");
    run32(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, "minneg_sq_u");
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "max_sq_u");
    run32(32'd0,         32'd12345,    1'b1, 64'd0,                   "zero_a");
    run32(32'd5,         32'd0,        1'b1, 64'd0,                   "zero_b");
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1,                   "m1_sq_s");
    run32(32'd7,         32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, "7xm1");

    // Abort an operation ten clocks in; nothing may complete afterwards.
    @(posedge clk); #2;
    if32.start = 1'b1; if32.a = 32'd123456; if32.b = 32'd789; if32.sgn = 1'b0;
    @(posedge clk); #2 if32.start = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", if32.busy, 0);
    chk("abort_done", if32.done, 0);
    chk("abort_p", if32.p, 0);
    chk("abort_Z", if32.Z, 1);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    d0 = done32;
    repeat (40) @(negedge clk);
    chk("abort_no_done", done32 - d0, 0);

    // start held high with operands changing every clock.
    d0 = done32; a0 = acc32;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #2;
      if32.start = 1'b1; if32.a = pick32(); if32.b = pick32();
      if32.sgn = 1'($urandom_range(0, 1));
    end
    #0 if32.start = 1'b0;
    for (int i = 0; i < 60 && q32.size() > 0; i++) @(negedge clk);
    chk("held_one_done_per_accept", done32 - d0, acc32 - a0);

    // Random start pulses at WIDTH=32, many landing while busy.
    a0 = acc32; n = 0;
    while (acc32 < a0 + 60 && n < 5000) begin
      @(posedge clk); #2;
      if32.start = ($urandom_range(0, 3) == 0);
      if32.a = pick32(); if32.b = pick32();
      if32.sgn = 1'($urandom_range(0, 1));
      n++;
    end
    #0 if32.start = 1'b0;

    // WIDTH=8: 1000 random accepted operations.
    n = 0;
    while (acc8 < 1000 && n < 30000) begin
      @(posedge clk); #2;
      if8.start = ($urandom_range(0, 2) != 0);
      if8.a = 8'($urandom); if8.b = 8'($urandom);
      if8.sgn = 1'($urandom_range(0, 1));
      n++;
    end
    #0 if8.start = 1'b0;
    chk("w8_accepts", (acc8 >= 1000), 1);

    for (int i = 0; i < 100 && (q32.size() > 0 || q8.size() > 0); i++) @(negedge clk);
    chk("drain32", q32.size(), 0);
    chk("drain8", q8.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
